// File: rtl/sync_fifo_status_if.sv
// Handshake and status bundle for sync_fifo_status.
// The master side drives data and control; the slave side is the FIFO itself.
interface sync_fifo_status_if #(
  parameter int WIDTH   = 32,
  parameter int W_LEVEL = 2
);
  logic [WIDTH-1:0]   w_data;
  logic               w_en;
  logic               r_en;
  logic [WIDTH-1:0]   r_data;
  logic               flush;
  logic [W_LEVEL-1:0] af_thresh;
  logic [W_LEVEL-1:0] ae_thresh;
  logic               err_clr;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [W_LEVEL-1:0] level;
  logic               overflow;
  logic               underflow;

  modport master (
    output w_data, w_en, r_en, flush, af_thresh, ae_thresh, err_clr,
    input  r_data, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );

  modport slave (
    input  w_data, w_en, r_en, flush, af_thresh, ae_thresh, err_clr,
    output r_data, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_status.sv
// Single-clock FIFO with wrap-around pointers, show-ahead read, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_status #(
  parameter int DEPTH   = 2,
  parameter int WIDTH   = 32,
  parameter int W_LEVEL = $clog2(DEPTH + 1),
  parameter int W_PTR   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_status_if.slave bus
);

  localparam logic [W_PTR-1:0]   PTR_LAST  = W_PTR'(DEPTH - 1);
  localparam logic [W_LEVEL-1:0] LEVEL_MAX = W_LEVEL'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [W_PTR-1:0]   w_ptr;
  logic [W_PTR-1:0]   r_ptr;
  logic [W_LEVEL-1:0] level;
  logic [W_LEVEL-1:0] level_next;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               overflow;
  logic               underflow;
  logic               overflow_set;
  logic               underflow_set;

  // Explicit wrap compare keeps non-power-of-2 depths legal; DEPTH=1 pins at 0.
  function automatic logic [W_PTR-1:0] ptr_next(input logic [W_PTR-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Status decode straight from the registered occupancy count.
  assign full  = (level == LEVEL_MAX);
  assign empty = (level == '0);

  // Flush wins over both requests, so nothing moves during a flush cycle.
  assign push = bus.w_en & ~full  & ~bus.flush;
  assign pop  = bus.r_en & ~empty & ~bus.flush;

  assign overflow_set  = bus.w_en & full  & ~bus.flush;
  assign underflow_set = bus.r_en & empty & ~bus.flush;

  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + W_LEVEL'(1);
      2'b01:   level_next = level - W_LEVEL'(1);
      default: level_next = level;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; contents are only
  // reachable through the pointers, which are reset, so a reset net here
  // would buy nothing and would block RAM inference.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[w_ptr] <= bus.w_data;
    end
  end

  // NOTE: every sequential assignment is non-blocking so all state updates
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else if (bus.flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else begin
      if (push) begin
        w_ptr <= ptr_next(w_ptr);
      end
      if (pop) begin
        r_ptr <= ptr_next(r_ptr);
      end
      level <= level_next;
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow_set  | (overflow  & ~bus.err_clr);
      underflow <= underflow_set | (underflow & ~bus.err_clr);
    end
  end

  always @(posedge clk) begin
    if (rst_n && overflow_set) begin
      $warning("sync_fifo_status: write while full, data dropped");
    end
    if (rst_n && underflow_set) begin
      $warning("sync_fifo_status: read while empty, request ignored");
    end
  end

  assign bus.r_data       = mem[r_ptr];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level >= bus.af_thresh);
  assign bus.almost_empty = (level <= bus.ae_thresh);
  assign bus.level        = level;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule
